// File: rtl/spi_slave_phy.sv
// SPI mode-0 slave PHY: synchronizes sclk/mosi/cs into clk and shifts words in and out.
// Define SPI_SLAVE_LSB_FIRST_EN to shift LSB first; MSB first otherwise.
`timescale 1ns/1ps

module spi_slave_phy #(
    parameter int SPI_DATA_WIDTH = 8,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sclk,
    input  logic                      mosi,
    input  logic                      cs,
    output logic                      miso,
    input  logic [SPI_DATA_WIDTH-1:0] data_in,
    output logic [SPI_DATA_WIDTH-1:0] data_out,
    output logic                      ready,
    output logic                      busy
);

    localparam int CW = $clog2(SPI_DATA_WIDTH + 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                    state_reg, state_next;
    logic [SYNC_STAGES-1:0]    sclk_sync_reg, mosi_sync_reg, cs_sync_reg;
    logic [SYNC_STAGES-1:0]    sclk_d, mosi_d, cs_d;
    logic                      sclk_prev_reg, cs_prev_reg;
    logic                      live_reg, armed_reg;
    logic [CW-1:0]             cnt_reg;
    logic [SPI_DATA_WIDTH-1:0] rx_reg, tx_reg, data_out_reg;
    logic                      ready_reg;

    logic                      sclk_s, mosi_s, cs_s;
    logic                      sclk_rise, sclk_fall, cs_fall;
    logic                      enter, running, cnt_last;
    logic [SPI_DATA_WIDTH-1:0] rx_shifted, tx_shifted;
    logic                      tx_bit;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_head
                assign sclk_d[gi] = sclk;
                assign mosi_d[gi] = mosi;
                assign cs_d[gi]   = cs;
            end else begin : g_tail
                assign sclk_d[gi] = sclk_sync_reg[gi-1];
                assign mosi_d[gi] = mosi_sync_reg[gi-1];
                assign cs_d[gi]   = cs_sync_reg[gi-1];
            end
        end
    endgenerate

    assign sclk_s    = sclk_sync_reg[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_reg[SYNC_STAGES-1];
    assign cs_s      = cs_sync_reg[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_reg;
    assign sclk_fall = ~sclk_s & sclk_prev_reg;
    // The cs chain resets to 1, so its first flush would look like a falling
    // edge; armed_reg only sets once a genuinely sampled high cs was seen.
    assign cs_fall   = armed_reg & cs_prev_reg & ~cs_s;
    assign cnt_last  = (cnt_reg == CW'(SPI_DATA_WIDTH - 1));

`ifdef SPI_SLAVE_LSB_FIRST_EN
    assign rx_shifted = {mosi_s, rx_reg[SPI_DATA_WIDTH-1:1]};
    assign tx_shifted = {1'b0, tx_reg[SPI_DATA_WIDTH-1:1]};
    assign tx_bit     = tx_reg[0];
`else
    assign rx_shifted = {rx_reg[SPI_DATA_WIDTH-2:0], mosi_s};
    assign tx_shifted = {tx_reg[SPI_DATA_WIDTH-2:0], 1'b0};
    assign tx_bit     = tx_reg[SPI_DATA_WIDTH-1];
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (cs_fall) state_next = ACTIVE;
            ACTIVE:  if (cs_s)    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign enter   = (state_reg == IDLE)   && (state_next == ACTIVE);
    assign running = (state_reg == ACTIVE) && (state_next == ACTIVE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            sclk_sync_reg <= '0;
            mosi_sync_reg <= '0;
            cs_sync_reg   <= '1;
            sclk_prev_reg <= 1'b0;
            cs_prev_reg   <= 1'b1;
            live_reg      <= 1'b0;
            armed_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            sclk_sync_reg <= sclk_d;
            mosi_sync_reg <= mosi_d;
            cs_sync_reg   <= cs_d;
            sclk_prev_reg <= sclk_s;
            cs_prev_reg   <= cs_s;
            live_reg      <= 1'b1;
            armed_reg     <= armed_reg | (live_reg & cs_sync_reg[0]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg      <= '0;
            rx_reg       <= '0;
            tx_reg       <= '0;
            data_out_reg <= '0;
            ready_reg    <= 1'b0;
        end else begin
            ready_reg <= 1'b0;
            if (enter) begin
                cnt_reg <= '0;
                rx_reg  <= '0;
                tx_reg  <= data_in;
            end else if (running) begin
                if (sclk_rise) begin
                    rx_reg <= rx_shifted;
                    if (cnt_last) begin
                        cnt_reg      <= '0;
                        data_out_reg <= rx_shifted;
                        ready_reg    <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                if (sclk_fall) begin
                    // Counter at zero means a word boundary: fetch the next word.
                    if (cnt_reg == '0) tx_reg <= data_in;
                    else               tx_reg <= tx_shifted;
                end
            end else begin
                cnt_reg <= '0;
                rx_reg  <= '0;
            end
        end
    end

    assign data_out = data_out_reg;
    assign ready    = ready_reg;
    assign busy     = (state_reg == ACTIVE);
    assign miso     = busy & tx_bit;

endmodule

// File: tb/tb_spi_slave_phy.sv
// Randomized self-checking bench for spi_slave_phy acting as an SPI mode-0 master.
`timescale 1ns/1ps

module tb_spi_slave_phy;

    localparam int W    = 8;
    localparam int SYNC = 3;
    localparam int HALF = 6;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         sclk = 1'b0;
    logic         mosi = 1'b0;
    logic         cs = 1'b1;
    logic         miso;
    logic [W-1:0] data_in = '0;
    logic [W-1:0] data_out;
    logic         ready;
    logic         busy;

    int           vectors = 0;
    int           miscompares = 0;
    int           ready_cnt = 0;
    logic [W-1:0] din_q[$];
    logic [W-1:0] rx_q[$];
    logic [W-1:0] exp_last = '0;

    always #5 clk = ~clk;

    spi_slave_phy #(.SPI_DATA_WIDTH(W), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .cs(cs), .miso(miso),
        .data_in(data_in), .data_out(data_out), .ready(ready), .busy(busy)
    );

    // Collects every completed word and feeds the next transmit word after each ready.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready === 1'b1) begin
                ready_cnt++;
                rx_q.push_back(data_out);
                if (din_q.size() > 0) data_in = din_q.pop_front();
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Wire position i of a word carries this bit index.
    function automatic int bit_idx(input int i);
`ifdef SPI_SLAVE_LSB_FIRST_EN
        return i;
`else
        return W - 1 - i;
`endif
    endfunction

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spi_bits(input logic [W-1:0] word, input int nbits, input int half,
                            output logic [W-1:0] rd);
        rd = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = word[bit_idx(i)];
            wait_clks(half);
            rd[bit_idx(i)] = miso;
            sclk = 1'b1;
            wait_clks(half);
            sclk = 1'b0;
        end
    endtask

    task automatic cs_high();
        wait_clks(HALF);
        cs = 1'b1;
        wait_clks(2 * HALF);
    endtask

    // One transaction: words[k] sent by the master, dins[k] is the word the slave must return.
    task automatic run_burst(input logic [W-1:0] words[$], input logic [W-1:0] dins[$],
                             input string name);
        logic [W-1:0] rd;
        logic [W-1:0] reads[$];
        data_in = dins[0];
        din_q.delete();
        for (int k = 1; k < dins.size(); k++) din_q.push_back(dins[k]);
        rx_q.delete();
        ready_cnt = 0;
        cs = 1'b0;
        foreach (words[k]) begin
            spi_bits(words[k], W, HALF, rd);
            reads.push_back(rd);
        end
        cs_high();
        vectors++;
        if (ready_cnt !== words.size()) begin
            miscompares++;
            $display("FAIL %s ready_count: got %0d expected %0d", name, ready_cnt, words.size());
        end
        foreach (words[k]) begin
            vectors++;
            if (k >= rx_q.size() || rx_q[k] !== words[k]) begin
                miscompares++;
                $display("FAIL %s data_out[%0d]: got %h expected %h", name, k,
                         (k < rx_q.size()) ? rx_q[k] : 'x, words[k]);
            end
            vectors++;
            if (reads[k] !== dins[k]) begin
                miscompares++;
                $display("FAIL %s miso_word[%0d]: got %h expected %h", name, k, reads[k], dins[k]);
            end
        end
        exp_last = words[words.size()-1];
    endtask

    task automatic test_reset();
        rst = 1'b0;
        wait_clks(3);
        vectors++; if (data_out !== '0) begin miscompares++; $display("FAIL reset data_out: got %h expected 00", data_out); end
        vectors++; if (ready !== 1'b0)  begin miscompares++; $display("FAIL reset ready: got %b expected 0", ready); end
        vectors++; if (busy !== 1'b0)   begin miscompares++; $display("FAIL reset busy: got %b expected 0", busy); end
        vectors++; if (miso !== 1'b0)   begin miscompares++; $display("FAIL reset miso: got %b expected 0", miso); end
        rst = 1'b1;
        wait_clks(SYNC + 4);
        exp_last = '0;
    endtask

    task automatic test_single();
        logic [W-1:0] rd;
        data_in = 8'hA5;
        rx_q.delete();
        ready_cnt = 0;
        cs = 1'b0;
        spi_bits(8'h3C, W, HALF, rd);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single busy_active: got %b expected 1", busy); end
        cs_high();
        vectors++; if (ready_cnt !== 1)    begin miscompares++; $display("FAIL single ready_count: got %0d expected 1", ready_cnt); end
        vectors++; if (data_out !== 8'h3C) begin miscompares++; $display("FAIL single data_out: got %h expected 3c", data_out); end
        vectors++; if (rd !== 8'hA5)       begin miscompares++; $display("FAIL single miso_word: got %h expected a5", rd); end
        vectors++; if (busy !== 1'b0)      begin miscompares++; $display("FAIL single busy_idle: got %b expected 0", busy); end
        vectors++; if (miso !== 1'b0)      begin miscompares++; $display("FAIL single miso_idle: got %b expected 0", miso); end
        exp_last = 8'h3C;
    endtask

    task automatic test_bit_order();
        logic [W-1:0] w[$];
        logic [W-1:0] d[$];
        w = '{8'h01};
        d = '{8'h80, 8'h00};
        run_burst(w, d, "bit_order");
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] w[$];
        logic [W-1:0] d[$];
        w = '{8'h01, 8'h02, 8'h03, 8'h04};
        d = '{8'hA5, 8'h11, 8'h12, 8'h13, 8'h14};
        run_burst(w, d, "back_to_back");
    endtask

    task automatic test_abort();
        logic [W-1:0] rd;
        logic [W-1:0] w[$];
        logic [W-1:0] d[$];
        ready_cnt = 0;
        cs = 1'b0;
        spi_bits(8'hFF, 5, HALF, rd);
        cs_high();
        vectors++; if (ready_cnt !== 0)     begin miscompares++; $display("FAIL abort ready_count: got %0d expected 0", ready_cnt); end
        vectors++; if (data_out !== exp_last) begin miscompares++; $display("FAIL abort data_out: got %h expected %h", data_out, exp_last); end
        vectors++; if (busy !== 1'b0)       begin miscompares++; $display("FAIL abort busy: got %b expected 0", busy); end
        w = '{8'h5A};
        d = '{W'($urandom), 8'h00};
        run_burst(w, d, "abort_next");
    endtask

    task automatic test_idle_sclk();
        ready_cnt = 0;
        cs = 1'b1;
        for (int i = 0; i < 2 * W; i++) begin
            mosi = 1'($urandom);
            wait_clks(HALF);
            sclk = 1'b1;
            wait_clks(HALF);
            sclk = 1'b0;
        end
        wait_clks(2 * HALF);
        vectors++; if (ready_cnt !== 0)       begin miscompares++; $display("FAIL idle_sclk ready_count: got %0d expected 0", ready_cnt); end
        vectors++; if (data_out !== exp_last) begin miscompares++; $display("FAIL idle_sclk data_out: got %h expected %h", data_out, exp_last); end
        vectors++; if (busy !== 1'b0)         begin miscompares++; $display("FAIL idle_sclk busy: got %b expected 0", busy); end
        vectors++; if (miso !== 1'b0)         begin miscompares++; $display("FAIL idle_sclk miso: got %b expected 0", miso); end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] rd;
        logic [W-1:0] w[$];
        logic [W-1:0] d[$];
        data_in = 8'hFF;
        cs = 1'b0;
        spi_bits(W'($urandom), 3, HALF, rd);
        rst = 1'b0;
        #2;
        vectors++; if (data_out !== '0) begin miscompares++; $display("FAIL rst_mid data_out: got %h expected 00", data_out); end
        vectors++; if (ready !== 1'b0)  begin miscompares++; $display("FAIL rst_mid ready: got %b expected 0", ready); end
        vectors++; if (busy !== 1'b0)   begin miscompares++; $display("FAIL rst_mid busy: got %b expected 0", busy); end
        vectors++; if (miso !== 1'b0)   begin miscompares++; $display("FAIL rst_mid miso: got %b expected 0", miso); end
        wait_clks(2);
        rst = 1'b1;
        exp_last = '0;
        ready_cnt = 0;
        wait_clks(SYNC + 2);
        spi_bits(8'hAA, W, HALF, rd);
        wait_clks(2 * HALF);
        vectors++; if (busy !== 1'b0)   begin miscompares++; $display("FAIL rst_mid busy_after: got %b expected 0", busy); end
        vectors++; if (ready_cnt !== 0) begin miscompares++; $display("FAIL rst_mid ready_count: got %0d expected 0", ready_cnt); end
        vectors++; if (data_out !== '0) begin miscompares++; $display("FAIL rst_mid data_out_after: got %h expected 00", data_out); end
        cs = 1'b1;
        wait_clks(2 * HALF);
        w = '{8'hC3};
        d = '{W'($urandom), 8'h00};
        run_burst(w, d, "rst_next");
    endtask

    task automatic test_latency();
        logic [W-1:0] rd;
        logic [W-1:0] w;
        int           lat;
        w = W'($urandom);
        data_in = W'($urandom);
        cs = 1'b0;
        wait_clks(HALF);
        spi_bits(w, W - 1, 2, rd);
        mosi = w[bit_idx(W - 1)];
        wait_clks(2);
        sclk = 1'b1;
        lat = 0;
        for (int k = 1; k <= 12 && lat == 0; k++) begin
            @(posedge clk);
            #1;
            if (ready === 1'b1) lat = k;
        end
        sclk = 1'b0;
        vectors++; if (lat !== SYNC + 1) begin miscompares++; $display("FAIL latency ready_delay: got %0d expected %0d", lat, SYNC + 1); end
        vectors++; if (data_out !== w)   begin miscompares++; $display("FAIL latency data_out: got %h expected %h", data_out, w); end
        cs_high();
        exp_last = w;
    endtask

    task automatic test_random();
        logic [W-1:0] w[$];
        logic [W-1:0] d[$];
        for (int b = 0; b < 4; b++) begin
            int n;
            n = int'($urandom_range(1, 6));
            w.delete();
            d.delete();
            for (int k = 0; k < n; k++) w.push_back(W'($urandom));
            for (int k = 0; k <= n; k++) d.push_back(W'($urandom));
            run_burst(w, d, $sformatf("random%0d", b));
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_bit_order();
        test_back_to_back();
        test_abort();
        test_idle_sclk();
        test_reset_mid();
        test_latency();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_slave_phy.md
SPI_SLAVE_PHY -- requirements
Module: spi_slave_phy

Interface
REQ-001 SHALL have parameter SPI_DATA_WIDTH, default 8: bits per SPI word.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on sclk, mosi and cs (minimum 2).
REQ-003 SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port sclk, input, 1: SPI clock from master, asynchronous to clk.
REQ-006 SHALL have port mosi, input, 1: serial data from master, asynchronous.
REQ-007 SHALL have port cs, input, 1: chip select, active-low, asynchronous.
REQ-008 SHALL have port miso, output, 1: serial data to master.
REQ-009 SHALL have port data_in, input, SPI_DATA_WIDTH: next word to transmit; feeds from buffer spi_data_send.
REQ-010 SHALL have port data_out, output, SPI_DATA_WIDTH: last complete received word; feeds buffer spi_data_receive.
REQ-011 SHALL have port ready, output, 1: one-clk pulse per completed word; feeds buffer spi_ready.
REQ-012 SHALL have port busy, output, 1: high while a transaction (cs low, synchronized) is in progress.

Function
REQ-013 SHALL operate in SPI mode 0 (CPOL=0, CPHA=0); clk SHALL be at least 4x sclk.
REQ-014 SHALL pass sclk, mosi, cs through SYNC_STAGES flops before use; edges detected on synchronized sclk against its previous value.
REQ-015 SHALL implement two-state FSM: IDLE -> ACTIVE on synchronized cs falling; ACTIVE -> IDLE on synchronized cs rising; busy = (state == ACTIVE).
REQ-016 On IDLE->ACTIVE: bit counter := 0, tx shift register := data_in.
REQ-017 In ACTIVE, each sclk rising edge: shift synchronized mosi into rx shift register, bit counter +1.
REQ-018 When bit counter reaches SPI_DATA_WIDTH: data_out := full rx word, ready high for exactly one clk in the same cycle data_out updates, counter wraps to 0.
REQ-019 ready latency: asserted SYNC_STAGES+1 clk cycles after the raw sclk rising edge of the last bit.
REQ-020 In ACTIVE, each sclk falling edge: if counter == 0, tx shift register := data_in (next word); else shift tx register by one.
REQ-021 miso SHALL equal the current tx output bit while ACTIVE, 0 while IDLE.
REQ-022 cs rising mid-word: partial rx bits discarded, counter := 0, no ready pulse, data_out unchanged.
REQ-023 sclk edges while IDLE SHALL be ignored.
REQ-024 Words per transaction unbounded; counter wraps each word with no gap cycles required.
REQ-025 data_out SHALL hold its value until the next completed word.

Reset
REQ-026 rst low SHALL asynchronously clear: FSM to IDLE, synchronizers (cs chain to 1, others to 0), counter, rx/tx shift registers, data_out = 0, ready = 0, busy = 0, miso = 0.
REQ-027 rst asserted mid-transaction SHALL abort it; after release the block waits for a new cs falling edge even if cs is already low.

Configuration
REQ-028 Macro SPI_SLAVE_LSB_FIRST_EN: when defined, rx and tx SHALL shift LSB first; when undefined, MSB first; framing, latency and ready timing identical in both builds.

Verification
REQ-029 MSB-first, data_in=8'hA5, master sends 8'h3C in one word -> data_out=8'h3C, one ready pulse, master reads 8'hA5 on miso.
REQ-030 Four back-to-back words 8'h01,8'h02,8'h03,8'h04, data_in changed after each ready to 8'h11..8'h14 -> four ready pulses, data_out sequence 01..04, master reads A5,11,12,13.
REQ-031 cs raised after 5 bits of 8'hFF -> no ready, data_out keeps previous value, next full word 8'h5A received correctly.
REQ-032 rst pulsed low after 3 bits with cs held low -> all outputs 0; sclk edges ignored until cs high then low; next word 8'hC3 received correctly.
REQ-033 SPI_SLAVE_LSB_FIRST_EN defined, master sends bit sequence 1,0,0,0,0,0,0,0 -> data_out=8'h01; data_in=8'h80 appears on miso as 0,...,0,1.
REQ-034 sclk at clk/4, SYNC_STAGES=3 -> ready asserted exactly 4 clk after last raw sclk rising edge.
